// File: rtl/ysyx_23060240_lsu_axi.sv
// Load/store unit: turns one IDU request at a time into AXI4-Lite read or write transactions.
// Misaligned accesses finish locally with an error; ready/valid rise delays are parameterised.
module ysyx_23060240_lsu_axi #(
    parameter int ADDR_W = 32,
    parameter int AR_DLY = 3,
    parameter int R_DLY  = 7,
    parameter int B_DLY  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_size,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);
    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B, RESP} state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [2:0]         size_q, size_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic               aw_pend_q, aw_pend_d;
    logic               w_pend_q, w_pend_d;
    logic [31:0]        res_q, res_d;
    logic               err_q, err_d;

    logic               misalign;
    logic [3:0]         strb_base;
    logic [31:0]        rd_shift;
    logic [31:0]        rd_ext;

    always_comb begin
        misalign = (req_size[1:0] == 2'b11)
                 | ((req_size[1:0] == 2'b01) & req_addr[0])
                 | ((req_size[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
        case (req_size[1:0])
            2'b00:   strb_base = 4'b0001;
            2'b01:   strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
        // Bytes sit at their lane offset on the bus; realign before extending.
        rd_shift = rdata >> {addr_q[1:0], 3'b000};
        case (size_q[1:0])
            2'b00:   rd_ext = size_q[2] ? {24'b0, rd_shift[7:0]}
                                        : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_ext = size_q[2] ? {16'b0, rd_shift[15:0]}
                                        : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        res_d     = res_q;
        err_d     = err_q;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    wdata_d = req_wdata << {req_addr[1:0], 3'b000};
                    wstrb_d = strb_base << req_addr[1:0];
                    if (misalign) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        res_d   = 32'b0;
                    end else if (req_we) begin
                        state_d   = WR_AW_W;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end else begin
                        state_d = RD_AR;
                        cnt_d   = 8'(AR_DLY);
                    end
                end
            end
            RD_AR: begin
                arvalid = (cnt_q == 8'd0);
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (arready) begin
                    state_d = RD_R;
                    cnt_d   = 8'(R_DLY);
                end
            end
            RD_R: begin
                rready = (cnt_q == 8'd0);
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (rvalid) begin
                    state_d = RESP;
                    err_d   = (rresp != 2'b00);
                    res_d   = (rresp != 2'b00) ? 32'b0 : rd_ext;
                end
            end
            WR_AW_W: begin
                awvalid   = aw_pend_q;
                wvalid    = w_pend_q;
                aw_pend_d = aw_pend_q & ~awready;
                w_pend_d  = w_pend_q & ~wready;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = WR_B;
                    cnt_d   = 8'(B_DLY);
                end
            end
            WR_B: begin
                bready = (cnt_q == 8'd0);
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (bvalid) begin
                    state_d = RESP;
                    err_d   = (bresp != 2'b00);
                    res_d   = 32'b0;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            addr_q    <= '0;
            size_q    <= 3'b0;
            wdata_q   <= 32'b0;
            wstrb_q   <= 4'b0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            res_q     <= 32'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            res_q     <= res_d;
            err_q     <= err_d;
        end
    end

    // Held low while reset is asserted so no request slips in during reset.
    assign req_ready  = (state_q == IDLE) & ~rst;
    assign araddr     = addr_q;
    assign awaddr     = addr_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign resp_rdata = res_q;
    assign resp_err   = err_q;
endmodule

// File: tb/tb_ysyx_23060240_lsu_axi.sv
// Directed bench for the LSU: a timeline/data model derived from scripted slave timing checks outputs every cycle.
module tb_ysyx_23060240_lsu_axi;
    localparam int AR = 3;
    localparam int RD = 7;
    localparam int BD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
    logic [2:0]  req_size = 3'b0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, awaddr, wdata;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic [3:0]  wstrb;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = 32'b0;
    logic [1:0]  rresp = 2'b0, bresp = 2'b0;

    ysyx_23060240_lsu_axi #(.ADDR_W(32), .AR_DLY(AR), .R_DLY(RD), .B_DLY(BD)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    // Model state: one transaction, its scripted slave timing, and the derived timeline.
    logic        m_active = 1'b0;
    logic        m_we, m_mis;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [2:0]  m_size;
    logic [1:0]  m_rresp, m_bresp;
    int T, a_on, r_on, aw_on, w_on, b_on;
    int ar_lo, ar_hi, rr_lo, rr_hi, aw_hi, w_hi, b_lo, b_hi, resp_c;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic inw(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    function automatic logic [31:0] exp_rdata();
        logic [31:0] v;
        int off;
        off = int'(m_addr % 4);
        if (m_mis || m_we || (m_rresp != 2'b00)) return 32'b0;
        v = m_rdata >> (8 * off);
        case (m_size % 4)
            0: begin v = v % 256;   if (!m_size[2] && v >= 128)   v = v + 32'hFFFFFF00; end
            1: begin v = v % 65536; if (!m_size[2] && v >= 32768) v = v + 32'hFFFF0000; end
            default: v = m_rdata;
        endcase
        return v;
    endfunction

    function automatic logic exp_err();
        if (m_mis) return 1'b1;
        return m_we ? (m_bresp != 2'b00) : (m_rresp != 2'b00);
    endfunction

    function automatic logic [31:0] exp_wdata();
        return m_wdata << (8 * int'(m_addr % 4));
    endfunction

    function automatic logic [31:0] exp_wstrb();
        int n;
        n = (m_size % 4 == 0) ? 1 : (m_size % 4 == 1) ? 2 : 4;
        return ((32'd1 << n) - 32'd1) << int'(m_addr % 4);
    endfunction

    task automatic plan();
        ar_lo = 0; ar_hi = -1; rr_lo = 0; rr_hi = -1;
        aw_hi = -1; w_hi = -1; b_lo = 0; b_hi = -1;
        if (m_mis) begin
            resp_c = T + 1;
        end else if (!m_we) begin
            ar_lo  = T + 1 + AR;
            ar_hi  = imax(ar_lo, a_on);
            rr_lo  = ar_hi + 1 + RD;
            rr_hi  = imax(rr_lo, r_on);
            resp_c = rr_hi + 1;
        end else begin
            aw_hi  = imax(T + 1, aw_on);
            w_hi   = imax(T + 1, w_on);
            b_lo   = imax(aw_hi, w_hi) + 1 + BD;
            b_hi   = imax(b_lo, b_on);
            resp_c = b_hi + 1;
        end
    endtask

    int obs_ar_rise, obs_ar_hs, obs_rr_rise, obs_b_rise, obs_resp_cyc, n_resp;
    logic [31:0] obs_rdata, obs_wdata;
    logic [3:0]  obs_wstrb;
    logic        obs_err;

    always @(negedge clk) begin
        if (m_active) begin
            if (cyc == T) begin
                obs_ar_rise = -1; obs_ar_hs = -1; obs_rr_rise = -1; obs_b_rise = -1;
                obs_resp_cyc = -1; n_resp = 0;
                obs_rdata = 32'hX; obs_wdata = 32'hX; obs_wstrb = 4'hX; obs_err = 1'bX;
            end
            chk1("req_ready",  req_ready,  (cyc <= T) || (cyc > resp_c));
            chk1("arvalid",    arvalid,    inw(cyc, ar_lo, ar_hi));
            chk1("rready",     rready,     inw(cyc, rr_lo, rr_hi));
            chk1("awvalid",    awvalid,    m_we && !m_mis && inw(cyc, T + 1, aw_hi));
            chk1("wvalid",     wvalid,     m_we && !m_mis && inw(cyc, T + 1, w_hi));
            chk1("bready",     bready,     inw(cyc, b_lo, b_hi));
            chk1("resp_valid", resp_valid, cyc == resp_c);
            if (arvalid) chk("araddr", araddr, m_addr);
            if (awvalid) chk("awaddr", awaddr, m_addr);
            if (wvalid) begin
                chk("wdata", wdata, exp_wdata());
                chk("wstrb", {28'b0, wstrb}, exp_wstrb());
                obs_wdata = wdata;
                obs_wstrb = wstrb;
            end
            if (resp_valid) begin
                chk1("resp_err", resp_err, exp_err());
                chk("resp_rdata", resp_rdata, exp_rdata());
                n_resp++;
                obs_resp_cyc = cyc;
                obs_rdata = resp_rdata;
                obs_err = resp_err;
            end
            if (arvalid && obs_ar_rise < 0) obs_ar_rise = cyc - T;
            if (arvalid && arready) obs_ar_hs = cyc;
            if (rready && obs_rr_rise < 0) obs_rr_rise = cyc;
            if (bready && obs_b_rise < 0) obs_b_rise = cyc;
        end
    end

    task automatic slave_idle();
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    task automatic run(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input logic [1:0] rr, input logic [1:0] br,
                       input int da, input int dr, input int daw, input int dw, input int db);
        @(posedge clk); #1;
        T = cyc;
        m_we = we; m_size = size; m_addr = addr; m_wdata = wd; m_rdata = rd;
        m_rresp = rr; m_bresp = br;
        m_mis = (size % 4 == 3) || ((size % 4 == 1) && (addr % 2 != 0)) ||
                ((size % 4 == 2) && (addr % 4 != 0));
        a_on = T + da; r_on = T + dr; aw_on = T + daw; w_on = T + dw; b_on = T + db;
        plan();
        rdata = rd; rresp = rr; bresp = br;
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wd;
        m_active = 1'b1;
        while (cyc < resp_c + 1) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            arready = (cyc >= a_on);
            rvalid  = (cyc >= r_on);
            awready = (cyc >= aw_on);
            wready  = (cyc >= w_on);
            bvalid  = (cyc >= b_on);
        end
        @(negedge clk); #1;
        m_active = 1'b0;
        slave_idle();
    endtask

    initial begin
        #1;
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_awvalid", awvalid, 1'b0);
        chk1("rst_wvalid", wvalid, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_wstrb", {28'b0, wstrb}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // lb across the top byte lane, slow arready
        run(1'b0, 3'b000, 32'h80000003, 32'h0, 32'h80FF1234, 2'b00, 2'b00, 6, 20, 0, 0, 0);
        chk("lb_ar_rise", obs_ar_rise, 4);
        chk("lb_rready_gap", obs_rr_rise - obs_ar_hs, 8);
        chk("lb_rdata", obs_rdata, 32'hFFFFFF80);
        run(1'b0, 3'b100, 32'h80000003, 32'h0, 32'h80FF1234, 2'b00, 2'b00, 1, 14, 0, 0, 0);
        chk("lbu_rdata", obs_rdata, 32'h00000080);
        // sh: awready early, wready late
        run(1'b1, 3'b001, 32'h80000002, 32'h0000ABCD, 32'h0, 2'b00, 2'b00, 0, 0, 1, 5, 10);
        chk("sh_wstrb", {28'b0, obs_wstrb}, 32'hC);
        chk("sh_wdata", obs_wdata, 32'hABCD0000);
        chk("sh_bready_rise", obs_b_rise - T, 8);
        chk("sh_resp_count", n_resp, 1);
        // misaligned lw
        run(1'b0, 3'b010, 32'h80000001, 32'h0, 32'h11111111, 2'b00, 2'b00, 1, 1, 1, 1, 1);
        chk("mis_resp_cyc", obs_resp_cyc - T, 1);
        chk1("mis_err", obs_err, 1'b1);
        chk("mis_no_arvalid", obs_ar_rise, -1);
        // lw with SLVERR, arready withheld ~20 cycles
        run(1'b0, 3'b010, 32'h80000004, 32'h0, 32'h12345678, 2'b10, 2'b00, 25, 40, 0, 0, 0);
        chk1("slverr_err", obs_err, 1'b1);
        chk("slverr_rdata", obs_rdata, 32'h0);
        run(1'b0, 3'b001, 32'h80000002, 32'h0, 32'h80015555, 2'b00, 2'b00, 4, 16, 0, 0, 0);
        chk("lh_rdata", obs_rdata, 32'hFFFF8001);
        run(1'b0, 3'b101, 32'h80000000, 32'h0, 32'h1234F00D, 2'b00, 2'b00, 4, 16, 0, 0, 0);
        run(1'b0, 3'b000, 32'h80000001, 32'h0, 32'h00007F00, 2'b00, 2'b00, 4, 16, 0, 0, 0);
        run(1'b0, 3'b010, 32'h80000008, 32'h0, 32'hDEADBEEF, 2'b00, 2'b00, 1, 12, 0, 0, 0);
        // sb: W before AW, error response
        run(1'b1, 3'b000, 32'h80000001, 32'h12345677, 32'h0, 2'b00, 2'b11, 0, 0, 4, 1, 1);
        // sw: simultaneous AW/W, bvalid already waiting
        run(1'b1, 3'b010, 32'h80000008, 32'hCAFEF00D, 32'h0, 2'b00, 2'b00, 0, 0, 1, 1, 1);
        run(1'b0, 3'b011, 32'h80000000, 32'h0, 32'h0, 2'b00, 2'b00, 1, 1, 1, 1, 1);
        run(1'b1, 3'b001, 32'h80000001, 32'h5555AAAA, 32'h0, 2'b00, 2'b00, 1, 1, 1, 1, 1);

        // Reset while rready is high: lw with arready immediate, rvalid never arrives.
        @(posedge clk); #1;
        T = cyc;
        rdata = 32'h0; rresp = 2'b00;
        req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h80000010;
        while (cyc < T + 1 + AR + 1 + RD) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            arready = 1'b1;
        end
        chk1("pre_rst_rready", rready, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("async_rst_rready", rready, 1'b0);
        chk1("async_rst_arvalid", arvalid, 1'b0);
        chk1("async_rst_resp_valid", resp_valid, 1'b0);
        chk("async_rst_wstrb", {28'b0, wstrb}, 32'h0);
        slave_idle();
        @(posedge clk); #1 rst = 1'b0;
        #1 chk1("post_rst_req_ready", req_ready, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("post_rst_no_resp", resp_valid, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_23060240_lsu_axi.md
YSYX_23060240_LSU_AXI -- requirements
Module: ysyx_23060240_lsu_axi

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32: request and AXI address width.
REQ-002 SHALL provide parameter AR_DLY, default 3: extra cycles before arvalid rises.
REQ-003 SHALL provide parameter R_DLY, default 7: extra cycles before rready rises.
REQ-004 SHALL provide parameter B_DLY, default 2: extra cycles before bready rises.
REQ-005 SHALL provide port clk  in  1: the single clock; all logic on rising edge.
REQ-006 SHALL provide port rst  in  1: asynchronous, active-high reset.
REQ-007 SHALL provide port req_valid  in  1: request from IDU.
REQ-008 SHALL provide port req_ready  out  1: request accepted when both high.
REQ-009 SHALL provide port req_we  in  1: 1 store, 0 load.
REQ-010 SHALL provide port req_addr  in  ADDR_W: byte address.
REQ-011 SHALL provide port req_wdata  in  32: store data, right-aligned.
REQ-012 SHALL provide port req_size  in  3: [1:0] 00 byte, 01 half, 10 word, 11 reserved; [2] unsigned load.
REQ-013 SHALL provide port resp_valid  out  1: one-cycle completion pulse.
REQ-014 SHALL provide port resp_rdata  out  32: extended load result.
REQ-015 SHALL provide port resp_err  out  1: error flag, valid with resp_valid.
REQ-016 SHALL provide ports araddr out ADDR_W, arvalid out 1, arready in 1: AXI read address.
REQ-017 SHALL provide ports rdata in 32, rresp in 2, rvalid in 1, rready out 1: AXI read data.
REQ-018 SHALL provide ports awaddr out ADDR_W, awvalid out 1, awready in 1: AXI write address.
REQ-019 SHALL provide ports wdata out 32, wstrb out 4, wvalid out 1, wready in 1: AXI write data.
REQ-020 SHALL provide ports bresp in 2, bvalid in 1, bready out 1: AXI write response.

Function
REQ-021 SHALL implement FSM IDLE, RD_AR, RD_R, WR_AW_W, WR_B, RESP; req_ready = (state==IDLE); one outstanding request.
REQ-022 SHALL latch addr, wdata, size and we on acceptance (cycle T); bus outputs SHALL derive only from latched values.
REQ-023 SHALL detect misalignment (half with addr[0]=1, word with addr[1:0]!=0, size 11): no AXI transaction, RESP at T+1 with resp_err=1, resp_rdata=0.
REQ-024 Load: arvalid SHALL rise at T+1+AR_DLY, araddr = latched addr, both held stable until the arready handshake; arvalid SHALL drop the cycle after it.
REQ-025 Load: rready SHALL rise R_DLY+1 cycles after the AR handshake cycle, held until rvalid, dropped the cycle after; rdata captured on handshake.
REQ-026 Load result: shift captured rdata right by 8*addr[1:0], then zero- or sign-extend from bit 7 or 15 per req_size[2]; word passes unchanged.
REQ-027 Store: awvalid and wvalid SHALL rise at T+1 together; each SHALL drop independently after its own handshake; simultaneous or either-order handshakes SHALL be accepted.
REQ-028 Store: wdata = req_wdata << 8*addr[1:0]; wstrb = 0001, 0011 or 1111 shifted left by addr[1:0] for byte, half or word.
REQ-029 Store: bready SHALL rise B_DLY+1 cycles after the later of the AW/W handshakes, held until bvalid, dropped the cycle after.
REQ-030 resp_valid SHALL pulse exactly one cycle, the cycle after the R or B handshake; resp_err = (rresp!=0 or bresp!=0); resp_rdata = 0 on error or on store.
REQ-031 Delay parameters of 0 SHALL give rise at T+1 or at handshake+1; delay counters SHALL have width sufficient for any parameter value up to 255.

Reset
REQ-032 Assertion of rst SHALL immediately, and also mid-transaction, force IDLE; all valid/ready outputs, resp_valid, resp_err, resp_rdata, wstrb and counters SHALL go to 0; in-flight transactions SHALL be abandoned without a response.

Verification
REQ-033 lb at 0x80000003, rdata 0x80FF1234 -> arvalid rises T+4, rready rises AR-handshake+8, resp_rdata 0xFFFFFF80; lbu gives 0x00000080.
REQ-034 sh at 0x80000002, wdata 0x0000ABCD, awready at T+1, wready at T+5 -> wstrb 1100, wdata 0xABCD0000, bready rises T+8, one resp_valid pulse.
REQ-035 lw at 0x80000001 -> resp_valid and resp_err=1 at T+1, arvalid never asserted.
REQ-036 lw with rresp=2'b10 -> resp_err=1, resp_rdata=0; with arready held low for 20 cycles, arvalid and araddr remain stable.
REQ-037 rst asserted while rready is high -> rready and arvalid 0 without waiting for a clock edge; after release req_ready=1, resp_valid never pulses.
